// File: rtl/waterfall_writer_pkg.sv
// Shared constants for the waterfall path: FSM encoding, DFT read latency and
// default address widths used by the DFT stage, this writer and the display scanner.
package waterfall_writer_pkg;

  localparam int READ_LAT       = 2;
  localparam int DEF_LIMIT_BINS = 32;
  localparam int DEF_ROWS       = 32;
  localparam int DEF_BIN_W      = $clog2(DEF_LIMIT_BINS);
  localparam int DEF_ROW_W      = $clog2(DEF_ROWS);
  localparam int DEF_ADDR_W     = $clog2(DEF_ROWS * DEF_LIMIT_BINS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_REQ,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/waterfall_writer_if.sv
// DFT read port plus line-buffer write port; master is the writer side.
interface waterfall_writer_if
  import waterfall_writer_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int FREQ_W = 16,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              sdft_ready;
  logic              sdft_read;
  logic [BIN_W-1:0]  sdft_bin_addr;
  logic [FREQ_W-1:0] sdft_bin_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  sdft_ready, sdft_bin_out,
    output sdft_read, sdft_bin_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output sdft_ready, sdft_bin_out,
    input  sdft_read, sdft_bin_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/waterfall_writer_bin_scale.sv
// Magnitude to pixel intensity: right shift then saturate to the pixel range.
module bin_scale #(
  parameter int FREQ_W = 16,
  parameter int PIX_W  = 4,
  parameter int SHIFT  = 2
) (
  input  logic [FREQ_W-1:0] mag,
  output logic [PIX_W-1:0]  pix
);
  localparam logic [FREQ_W-1:0] PIX_MAX = FREQ_W'((1 << PIX_W) - 1);

  logic [FREQ_W-1:0] shifted;

  // full-width compare so large magnitudes clip instead of wrapping
  assign shifted = mag >> SHIFT;
  assign pix     = (shifted > PIX_MAX) ? {PIX_W{1'b1}} : shifted[PIX_W-1:0];
endmodule

// File: rtl/waterfall_writer.sv
// Sweeps all DFT bins on each frame tick and writes one scaled pixel row into
// the circular waterfall line buffer.
module waterfall_writer
  import waterfall_writer_pkg::*;
#(
  parameter int LIMIT_BINS = DEF_LIMIT_BINS,
  parameter int FREQ_W     = 16,
  parameter int PIX_W      = 4,
  parameter int SHIFT      = 2,
  parameter int ROWS       = DEF_ROWS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  waterfall_writer_if.master      bus,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                    row_done,
  output logic                    busy
);
  localparam int BIN_W = $clog2(LIMIT_BINS);

  state_t                         state;
  logic                           pending;
  logic [BIN_W-1:0]               bin_cnt;
  logic                           drain_cnt;
  logic [READ_LAT:1]              vld_pipe;
  logic [READ_LAT:1][BIN_W-1:0]   bin_pipe;
  logic [PIX_W-1:0]               pix;

  bin_scale #(
    .FREQ_W (FREQ_W),
    .PIX_W  (PIX_W),
    .SHIFT  (SHIFT)
  ) u_scale (
    .mag (bus.sdft_bin_out),
    .pix (pix)
  );

  assign bus.sdft_read     = (state == S_REQ) || (state == S_SWEEP);
  assign bus.sdft_bin_addr = bin_cnt;

  // magnitude arrives READ_LAT cycles after its address; the pipe tail lines up with it
  assign bus.wr_en   = vld_pipe[READ_LAT];
  assign bus.wr_addr = {cur_row, bin_pipe[READ_LAT]};
  assign bus.wr_data = vld_pipe[READ_LAT] ? pix : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      bin_cnt   <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
      bin_pipe  <= '0;
      cur_row   <= '0;
      row_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LAT-1:1], state == S_SWEEP};
      bin_pipe <= {bin_pipe[READ_LAT-1:1], bin_cnt};
      row_done <= 1'b0;

      if (frame_tick && state != S_IDLE) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_tick || pending) begin
            state   <= S_WAIT_RDY;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_WAIT_RDY: begin
          bin_cnt <= '0;
          if (bus.sdft_ready) state <= S_REQ;
        end
        S_REQ: state <= S_SWEEP;
        S_SWEEP: begin
          if (bin_cnt == BIN_W'(LIMIT_BINS - 1)) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            bin_cnt <= bin_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state    <= S_DONE;
            row_done <= 1'b1;
          end
        end
        S_DONE: begin
          cur_row <= cur_row + 1'b1;
          state   <= S_IDLE;
          busy    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_waterfall_writer.sv
// Scoreboard bench for waterfall_writer against a 2-cycle-latency DFT read model.
module tb_waterfall_writer;
  localparam int LB   = 32;
  localparam int RW   = 4;
  localparam int FW   = 16;
  localparam int PW   = 4;
  localparam int SH   = 2;
  localparam int BW   = $clog2(LB);
  localparam int ROWW = $clog2(RW);
  localparam int AW   = $clog2(RW * LB);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic [ROWW-1:0] cur_row;
  logic            row_done;
  logic            busy;
  logic            sat = 1'b0;
  logic [BW-1:0]   a1;

  waterfall_writer_if #(.BIN_W(BW), .FREQ_W(FW), .PIX_W(PW), .ADDR_W(AW)) bus ();

  waterfall_writer #(
    .LIMIT_BINS (LB), .FREQ_W (FW), .PIX_W (PW), .SHIFT (SH), .ROWS (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .bus        (bus),
    .cur_row    (cur_row),
    .row_done   (row_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // DFT read model: address registered, magnitude registered one cycle later
  always @(posedge clk) begin
    a1 <= bus.sdft_bin_addr;
    bus.sdft_bin_out <= sat ? 16'hFFFF : FW'(5 * int'(a1));
  end

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  logic [AW+PW-1:0] sb[$];
  logic [AW+PW-1:0] sb_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_pix(input int b);
    int m;
    m = sat ? 32'hFFFF : 5 * b;
    m = m >> SH;
    return PW'((m > 15) ? 15 : m);
  endfunction

  task automatic push_row(input int row, input int nb);
    logic [AW-1:0] a;
    for (int b = 0; b < nb; b++) begin
      a = AW'(row * LB + b);
      sb.push_back({a, exp_pix(b)});
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (sb.size() == 0) chk("wr_unexpected", 32'(bus.wr_addr), 32'hFFFF);
      else begin
        sb_e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(sb_e[AW+PW-1:PW]));
        chk("wr_data", 32'(bus.wr_data), 32'(sb_e[PW-1:0]));
      end
    end
    if (row_done) rd_cnt++;
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_row(input int exp_row);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (row_done) seen = 1'b1;
    end
    chk("row_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("cur_row", 32'(cur_row), 32'(exp_row));
      chk("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, rd_hi, base;
    bit hit;
    bus.sdft_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(bus.sdft_read), 0);
    chk("rst_addr", 32'(bus.sdft_bin_addr), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_row", 32'(cur_row), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_row_done", 32'(row_done), 0);
    reset = 1'b0;
    @(negedge clk);

    // single row, tick-to-first-write latency
    push_row(0, LB);
    frame_tick = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (bus.wr_en) lat = i;
    end
    chk("tick_to_wr", 32'(lat), 32'd5);
    wait_row(1);

    // DFT busy
    push_row(1, LB);
    bus.sdft_ready = 1'b0;
    tick();
    rd_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.sdft_read) rd_hi++;
    end
    chk("read_while_busy", 32'(rd_hi), 0);
    bus.sdft_ready = 1'b1;
    @(negedge clk);
    chk("read_after_ready", 32'(bus.sdft_read), 1);
    chk("req_addr", 32'(bus.sdft_bin_addr), 0);
    wait_row(2);

    // ticks during sweep: one extra row, rest dropped
    push_row(2, LB);
    push_row(3, LB);
    tick();
    for (int i = 0; i < 20 && !bus.sdft_read; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    repeat (3) @(negedge clk);
    tick();
    wait_row(3);
    @(negedge clk);
    chk("pending_restart", 32'(busy), 1);
    wait_row(0);
    repeat (60) @(negedge clk);
    chk("dropped_ticks", 32'(busy), 0);
    chk("sb_empty_pend", 32'(sb.size()), 0);

    // fifth row wraps to row 0
    push_row(0, LB);
    tick();
    wait_row(1);

    // saturation
    sat = 1'b1;
    push_row(1, LB);
    tick();
    wait_row(2);
    sat = 1'b0;

    // mid-sweep reset at bin 10: bins 0..8 already written by then
    push_row(2, 9);
    tick();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.sdft_read && bus.sdft_bin_addr == BW'(10)) hit = 1'b1;
    end
    chk("reached_bin10", 32'(hit), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_read", 32'(bus.sdft_read), 0);
    chk("mrst_wr_en", 32'(bus.wr_en), 0);
    chk("mrst_row", 32'(cur_row), 0);
    chk("mrst_busy", 32'(busy), 0);
    reset = 1'b0;
    base = rd_cnt;
    repeat (40) @(negedge clk);
    chk("mrst_no_row_done", 32'(rd_cnt - base), 0);
    chk("sb_empty_mrst", 32'(sb.size()), 0);
    push_row(0, LB);
    tick();
    wait_row(1);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
